// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner with per-frame input snapshot,
// anti-ghost blanking, leading-zero blanking and per-digit blink.
module seg7_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DIN,
  input  logic [3:0]  DP_IN,
  input  logic [3:0]  BLINK_EN,
  input  logic        LZB,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        FRAME
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [7:0]    F_LAST  = 8'(BLINK_FRAMES - 1);

  logic [PW-1:0] p_q, p_d;
  logic [1:0]    i_q, i_d;
  logic [15:0]   din_s_q, din_s_d;
  logic [3:0]    dp_s_q, dp_s_d;
  logic [3:0]    blk_s_q, blk_s_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          bp_q, bp_d;
  logic          frame_q, frame_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic       wrap;
  logic       snap;
  logic [3:0] nib;
  logic       lz_sup;
  logic       en;

  function automatic logic [6:0] bcd7(input logic [3:0] n);
    unique case (n)
      4'd0:    bcd7 = 7'h40;
      4'd1:    bcd7 = 7'h79;
      4'd2:    bcd7 = 7'h24;
      4'd3:    bcd7 = 7'h30;
      4'd4:    bcd7 = 7'h19;
      4'd5:    bcd7 = 7'h12;
      4'd6:    bcd7 = 7'h02;
      4'd7:    bcd7 = 7'h78;
      4'd8:    bcd7 = 7'h00;
      4'd9:    bcd7 = 7'h10;
      default: bcd7 = 7'h3F;
    endcase
  endfunction

  always_comb begin
    wrap = (p_q == P_LAST);
    snap = wrap && (i_q == 2'd3);
    p_d  = wrap ? '0 : p_q + 1'b1;
    i_d  = wrap ? i_q + 2'd1 : i_q;

    din_s_d = snap ? DIN : din_s_q;
    dp_s_d  = snap ? DP_IN : dp_s_q;
    blk_s_d = snap ? BLINK_EN : blk_s_q;
    frame_d = snap;

    fcnt_d = fcnt_q;
    bp_d   = bp_q;
    if (snap) begin
      if (fcnt_q == F_LAST) begin
        fcnt_d = '0;
        bp_d   = ~bp_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    nib = 4'd0;
    unique case (i_q)
      2'd0: nib = din_s_q[3:0];
      2'd1: nib = din_s_q[7:4];
      2'd2: nib = din_s_q[11:8];
      2'd3: nib = din_s_q[15:12];
    endcase

    // only the two leftmost digits may be blanked as leading zeros
    lz_sup = LZB && (din_s_q[15:12] == 4'd0) &&
             ((i_q == 2'd3) ||
              ((i_q == 2'd2) && (din_s_q[11:8] == 4'd0)));

    en = (p_q >= P_BLANK) && !lz_sup &&
         !(bp_q && blk_s_q[i_q]);

    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en) begin
      an_d[i_q] = 1'b0;
      seg_d     = bcd7(nib);
      dp_d      = ~dp_s_q[i_q];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_q     <= '0;
      i_q     <= '0;
      din_s_q <= '0;
      dp_s_q  <= '0;
      blk_s_q <= '0;
      fcnt_q  <= '0;
      bp_q    <= 1'b0;
      frame_q <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      p_q     <= p_d;
      i_q     <= i_d;
      din_s_q <= din_s_d;
      dp_s_q  <= dp_s_d;
      blk_s_q <= blk_s_d;
      fcnt_q  <= fcnt_d;
      bp_q    <= bp_d;
      frame_q <= frame_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign AN    = an_q;
  assign SEG   = seg_q;
  assign DP    = dp_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed table-driven bench for seg7_scan with a small scan configuration
// (8 cycles per slot, 2 dead cycles, blink half-period of 2 frames).
module tb_seg7_scan;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] DIN = '0;
  logic [3:0]  DP_IN = '0;
  logic [3:0]  BLINK_EN = '0;
  logic        LZB = 1'b0;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        FRAME;

  int total = 0;
  int bad = 0;

  seg7_scan #(
    .SCAN_DIV(8),
    .BLANK_CYC(2),
    .BLINK_FRAMES(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .DIN(DIN),
    .DP_IN(DP_IN),
    .BLINK_EN(BLINK_EN),
    .LZB(LZB),
    .AN(AN),
    .SEG(SEG),
    .DP(DP),
    .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  dp;
    logic        lzb;
    logic [3:0]  en;
    logic [27:0] seg;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int idx,
                       input logic [12:0] act,
                       input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got {frame,an,seg,dp}=%h want=%h",
               name, idx, act, exp);
    end
  endtask

  // checks one full frame (32 cycles), first sample is slot 0, P=0
  task automatic run_frame(input vec_t v, input string tag,
                           input int chg_at,
                           input logic [15:0] chg_din);
    int s;
    int p;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    for (int j = 0; j < 32; j++) begin
      @(negedge CLK);
      s  = j / 8;
      p  = j % 8;
      ea = 4'hF;
      es = 7'h7F;
      ed = 1'b1;
      if (p >= 2 && v.en[s]) begin
        ea[s] = 1'b0;
        es    = v.seg[7*s +: 7];
        ed    = ~v.dp[s];
      end
      check(tag, j, {FRAME, AN, SEG, DP}, {(j == 31), ea, es, ed});
      if (j == chg_at) DIN = chg_din;
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (FRAME !== 1'b1 && n < 100);
    total++;
    if (FRAME !== 1'b1) begin
      bad++;
      $display("FAIL wait_frame got FRAME=%b want=1 within 100 cycles",
               FRAME);
    end
  endtask

  task automatic apply(input vec_t v);
    DIN      = v.din;
    DP_IN    = v.dp;
    LZB      = v.lzb;
    BLINK_EN = 4'b0000;
  endtask

  initial begin
    vec_t z;
    vec_t t;
    logic [27:0] s40;
    s40 = {7'h40, 7'h40, 7'h40, 7'h40};

    tbl[0] = '{16'h5909, 4'b0000, 1'b0, 4'b1111,
               {7'h12, 7'h10, 7'h40, 7'h10}};
    tbl[1] = '{16'h0007, 4'b0000, 1'b1, 4'b0011,
               {7'h7F, 7'h7F, 7'h40, 7'h78}};
    tbl[2] = '{16'h0107, 4'b0000, 1'b1, 4'b0111,
               {7'h7F, 7'h79, 7'h40, 7'h78}};
    tbl[3] = '{16'h000A, 4'b0001, 1'b0, 4'b1111,
               {7'h40, 7'h40, 7'h40, 7'h3F}};
    tbl[4] = '{16'h1234, 4'b1010, 1'b0, 4'b1111,
               {7'h79, 7'h24, 7'h30, 7'h19}};
    tbl[5] = '{16'h5678, 4'b0110, 1'b0, 4'b1111,
               {7'h12, 7'h02, 7'h78, 7'h00}};
    tbl[6] = '{16'hFEDC, 4'b1111, 1'b1, 4'b1111,
               {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    tbl[7] = '{16'h0900, 4'b0000, 1'b1, 4'b0111,
               {7'h7F, 7'h10, 7'h40, 7'h40}};
    tbl[8] = '{16'h0000, 4'b0000, 1'b1, 4'b0011,
               {7'h7F, 7'h7F, 7'h40, 7'h40}};

    repeat (3) @(negedge CLK);
    check("reset", 0, {FRAME, AN, SEG, DP}, {1'b0, 4'hF, 7'h7F, 1'b1});

    // before the first snapshot the shadows hold 0000
    LZB = 1'b1;
    DIN = 16'h5909;
    RST = 1'b0;
    z = '{16'h0000, 4'b0000, 1'b1, 4'b0011, s40};
    run_frame(z, "post_reset", -1, 16'h0);

    for (int k = 0; k < 9; k++) begin
      apply(tbl[k]);
      wait_frame();
      run_frame(tbl[k], $sformatf("vec%0d", k), -1, 16'h0);
    end

    // mid-frame DIN change must not tear; back-to-back frames
    apply(tbl[4]);
    wait_frame();
    run_frame(tbl[4], "tear_old", 12, 16'h5678);
    t = tbl[5];
    t.dp = 4'b1010;
    run_frame(t, "tear_new", -1, 16'h0);
    run_frame(t, "free_run3", -1, 16'h0);
    run_frame(t, "free_run4", -1, 16'h0);

    // blink: fresh reset so the phase starts from a known point
    @(negedge CLK);
    RST      = 1'b1;
    DIN      = 16'h5678;
    DP_IN    = 4'b0000;
    LZB      = 1'b0;
    BLINK_EN = 4'b0001;
    @(negedge CLK);
    RST = 1'b0;
    z = '{16'h0000, 4'b0000, 1'b0, 4'b1111, s40};
    run_frame(z, "blink_pre", -1, 16'h0);
    t = tbl[5];
    t.dp = 4'b0000;
    t.en = 4'b1111; run_frame(t, "blink_f1", -1, 16'h0);
    t.en = 4'b1110; run_frame(t, "blink_f2", -1, 16'h0);
    t.en = 4'b1110; run_frame(t, "blink_f3", -1, 16'h0);
    t.en = 4'b1111; run_frame(t, "blink_f4", -1, 16'h0);
    t.en = 4'b1111; run_frame(t, "blink_f5", -1, 16'h0);
    t.en = 4'b1110; run_frame(t, "blink_f6", -1, 16'h0);

    // reset mid-slot while digit 1 is lit
    repeat (12) @(negedge CLK);
    check("pre_rst", 0, {FRAME, AN, SEG, DP}, {1'b0, 4'hD, 7'h78, 1'b1});
    #3;
    RST = 1'b1;
    #1;
    check("mid_rst", 0, {FRAME, AN, SEG, DP}, {1'b0, 4'hF, 7'h7F, 1'b1});
    @(negedge CLK);
    check("mid_rst", 1, {FRAME, AN, SEG, DP}, {1'b0, 4'hF, 7'h7F, 1'b1});
    BLINK_EN = 4'b0000;
    RST = 1'b0;
    run_frame(z, "after_rst", -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles per digit slot (legal range 4..2^20).
REQ-002 The block SHALL have parameter BLANK_CYC, default 16, meaning anti-ghost dead cycles at the start of each slot (legal range 1..SCAN_DIV-2).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 64, meaning frames per blink half-period (legal range 1..255).
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port DIN, input, 16 bits: four BCD nibbles; DIN[3:0] is rightmost digit 0; typically {minutes CNT, seconds CNT}.
REQ-007 The block SHALL have port DP_IN, input, 4 bits: decimal-point request per digit, 1 = lit.
REQ-008 The block SHALL have port BLINK_EN, input, 4 bits: blink request per digit.
REQ-009 The block SHALL have port LZB, input, 1 bit: leading-zero blanking enable, sampled every cycle.
REQ-010 The block SHALL have port AN, output, 4 bits: active-low digit anodes; AN[i] drives digit i.
REQ-011 The block SHALL have port SEG, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.
REQ-012 The block SHALL have port DP, output, 1 bit: active-low decimal point.
REQ-013 The block SHALL have port FRAME, output, 1 bit: one-cycle pulse marking each new input snapshot.

Function
REQ-014 The prescaler P SHALL count 0..SCAN_DIV-1 and wrap to 0; at wrap, digit index I SHALL advance 0->1->2->3->0.
REQ-015 When P==SCAN_DIV-1 and I==3, the block SHALL copy DIN, DP_IN and BLINK_EN into shadow registers at that edge; all display decisions SHALL use shadow values only.
REQ-016 FRAME SHALL be 1 for exactly the one cycle following each snapshot edge, and 0 otherwise.
REQ-017 The blink frame counter SHALL increment at each snapshot; on reaching BLINK_FRAMES it SHALL reset to 0 and toggle blink phase BP.
REQ-018 AN, SEG and DP SHALL be registered, each cycle's values being a function of the previous cycle's P, I, shadow, BP and LZB (1-cycle latency).
REQ-019 All AN bits SHALL be 1 when P < BLANK_CYC; otherwise only AN[I] SHALL be 0, unless digit I is suppressed.
REQ-020 Digit I SHALL be suppressed (all AN 1) when BP==1 and shadow BLINK_EN[I]==1.
REQ-021 With LZB==1: digit 3 SHALL be suppressed if nibble3==0; digit 2 SHALL be suppressed if nibble3==0 and nibble2==0; digits 1 and 0 SHALL never be LZB-suppressed.
REQ-022 SEG SHALL decode shadow nibble I: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10; values 10..15 SHALL display dash 0x3F.
REQ-023 DP SHALL equal ~shadow DP_IN[I] while AN[I]==0, and 1 otherwise.
REQ-024 When no digit is enabled, SEG SHALL be 0x7F and DP SHALL be 1.
REQ-025 DIN changes between snapshots SHALL have no visible effect until the next snapshot (no tearing within a frame).

Reset
REQ-026 While RST==1: P=0, I=0, shadows=0, frame counter=0, BP=0, AN=4'hF, SEG=7'h7F, DP=1, FRAME=0.
REQ-027 After RST release, the first slot SHALL be digit 0 starting at P=0; until the first snapshot the display SHALL show 0000 with LZB applied.
REQ-028 RST asserted mid-slot SHALL blank all outputs within the same cycle and discard the blink phase.

Verification (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-029 DIN=0x5909, LZB=0, after first FRAME -> per slot: 2 cycles AN=F, then 6 cycles AN=E/D/B/7 with SEG=0x10/0x40/0x10/0x12.
REQ-030 DIN=0x0007, LZB=1 -> digits 3 and 2 never enabled; digit 1 shows 0x40, digit 0 shows 0x78; with DIN=0x0107, digit 2 shows 0x79.
REQ-031 DIN changed from 0x1234 to 0x5678 mid-frame -> old value displayed until next FRAME pulse, new value from following slot 0.
REQ-032 BLINK_EN=4'b0001 -> digit 0 enabled for 2 frames, suppressed for 2 frames, repeating; other digits unaffected.
REQ-033 Nibble 0xA with DP_IN=4'b0001 -> digit 0 shows SEG=0x3F, DP=0; RST pulse mid-slot -> AN=F, SEG=7F, DP=1 immediately.
REQ-034 Free-run 4 frames -> FRAME pulses exactly every 32 cycles, always 1 cycle wide.
